// File: rtl/pipeline_pkg.sv
// Shared types and widths for the instruction-memory loader slice.
// Latency: n/a (constants and the loader state encoding only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int BYTE_W = 8;
  localparam int HDR_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    LOAD  = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: gathers four accepted bytes MSB first into one 32-bit word.
// Latency: word_vld_o is combinational with the 4th byte; the word includes that byte.
// Backpressure: none inside; the caller only presents bytes it has accepted.
module byte_packer
  import pipeline_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_dat_i,
  output logic              word_vld_o,
  output logic [WORD_W-1:0] word_dat_o
);

  logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
  logic [1:0]               cnt_q, cnt_d;

  // Shift in each accepted byte; the 2-bit count wraps to 0 after the 4th byte.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_vld_i) begin
      shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], byte_dat_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Partial word is dropped on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);
  assign word_dat_o = {shift_q, byte_dat_i};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a 16-bit-length-prefixed byte image into instruction memory, holding the CPU meanwhile.
// Latency: mem_we pulses for one cycle, the cycle after a word's 4th byte is accepted.
// Backpressure: byte_ready only in HDR0/HDR1/LOAD/CHECK; CHECK trailer exists only with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import pipeline_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [HDR_W-1:0] DEPTH_W = HDR_W'(DEPTH);

  ld_state_e         state_q, state_d;
  logic [HDR_W-1:0]  cnt_q, cnt_d;
  logic [HDR_W-1:0]  idx_q, idx_d;
  logic [HDR_W-1:0]  idx_inc, n_w;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] pk_word;
  logic              acc, load_acc, pk_vld, pk_clr;

  assign byte_ready = (state_q == HDR0) || (state_q == HDR1) ||
                      (state_q == LOAD) || (state_q == CHECK);
  assign acc        = byte_valid && byte_ready;
  assign load_acc   = acc && (state_q == LOAD);
  assign idx_inc    = idx_q + HDR_W'(1);
  assign n_w        = {cnt_q[HDR_W-1:BYTE_W], byte_in};

  byte_packer u_packer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clr_i      (pk_clr),
    .byte_vld_i (load_acc),
    .byte_dat_i (byte_in),
    .word_vld_o (pk_vld),
    .word_dat_o (pk_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  // Running XOR of payload bytes, restarted with every session.
  always_comb begin
    csum_d = csum_q;
    if (pk_clr) begin
      csum_d = '0;
    end else if (load_acc) begin
      csum_d = csum_q ^ byte_in;
    end
  end

  // Checksum register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Session sequencing: header, word assembly, write strobe, optional trailer check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pk_clr  = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR0;
          cnt_d   = '0;
          idx_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      HDR0: begin
        if (acc) begin
          cnt_d   = {byte_in, {BYTE_W{1'b0}}};
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (acc) begin
          cnt_d   = n_w;
          state_d = ((n_w == '0) || (n_w > DEPTH_W)) ? ERR : LOAD;
        end
      end
      LOAD: begin
        if (pk_vld) begin
          wdata_d = pk_word;
          addr_d  = BASE_ADDR + (WORD_W'(idx_q) << 2);
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_inc;
        if (idx_inc < cnt_q) begin
          state_d = LOAD;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (acc) begin
          state_d = (byte_in == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the held write address/data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of sessions, hand-written corner cases and random sessions.
// Expected memory writes and final status come from a session-level model of the loader rules.
// Bytes are driven and outputs sampled on the falling clock edge.
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] got_wr[$];

  // Record every cycle in which the write strobe is high.
  always @(negedge clock) begin
    if (mem_we) got_wr.push_back({mem_addr, mem_wdata});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present one byte and hold it until the cycle it is taken.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!byte_ready && t < 40) begin
      @(negedge clock);
      t++;
    end
    if (!byte_ready) chk("byte_ready_wait", byte_ready, 1'b1);
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clock);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  function automatic logic [7:0] xor_of(input logic [31:0] words[$], input logic [15:0] n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < int'(n) && i < words.size(); i++)
      x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    return x;
  endfunction

  // Session outcome as {done, error}.
  function automatic logic [1:0] model_status(input logic [15:0] n, input logic [31:0] words[$],
                                              input logic [7:0] trailer);
    if (n == 16'd0 || int'(n) > DEPTH) return 2'b01;
`ifdef IMEM_LOADER_CHECKSUM_EN
    return (xor_of(words, n) == trailer) ? 2'b10 : 2'b01;
`else
    return (trailer === trailer) ? 2'b10 : 2'b10;
`endif
  endfunction

  task automatic finish_check(input string tag, input logic [63:0] exp_wr[$],
                              input logic [1:0] est, output logic [1:0] st);
    int t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clock);
      t++;
    end
    idle(2);
    st = {done, error};
    chk({tag, " status"}, 64'(st), 64'(est));
    chk({tag, " cpu_hold"}, 64'(cpu_hold), est[1] ? 64'd0 : 64'd1);
    chk({tag, " byte_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, " wr_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      chk($sformatf("%s wr%0d", tag, i), got_wr[i], exp_wr[i]);
  endtask

  task automatic run_session(input string tag, input logic [15:0] n, input logic [31:0] words[$],
                             input int gap, input logic [7:0] trailer, output logic [1:0] st);
    logic [63:0] exp_wr[$];
    logic [31:0] w;
    bit          ok;
    ok = (n != 16'd0) && (int'(n) <= DEPTH);
    got_wr.delete();
    pulse_start();
    send_byte(n[15:8]);
    idle(gap);
    send_byte(n[7:0]);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        w = words[i];
        exp_wr.push_back({BASE + 32'(4 * i), w});
        for (int k = 0; k < 4; k++) begin
          idle(gap);
          send_byte(w[8*(3-k) +: 8]);
        end
        chk($sformatf("%s we_latency%0d", tag, i), 64'(mem_we), 64'd1);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      idle(gap);
      send_byte(trailer);
`endif
    end
    finish_check(tag, exp_wr, model_status(n, words, trailer), st);
  endtask

  typedef struct {
    logic [15:0] n;
    int          gap;
    logic [31:0] w0;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  localparam int NV = 8;

  initial begin
    vec_t        tbl[NV];
    logic [31:0] words[$];
    logic [63:0] exp_wr[$];
    logic [1:0]  st;
    logic [15:0] n;
    logic [7:0]  tr;
    int          gap;

    tbl[0] = '{16'h0001, 0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    tbl[1] = '{16'h0000, 0, 32'h0000_0000, 1'b0, 1'b1};
    tbl[2] = '{16'h0041, 0, 32'h0000_0000, 1'b0, 1'b1};
    tbl[3] = '{16'h0002, 3, 32'h0BAD_F00D, 1'b1, 1'b0};
    tbl[4] = '{16'h0100, 1, 32'h0000_0000, 1'b0, 1'b1};
    tbl[5] = '{16'h0040, 0, 32'hCAFE_0040, 1'b1, 1'b0};
    tbl[6] = '{16'hFFFF, 0, 32'h0000_0000, 1'b0, 1'b1};
    tbl[7] = '{16'h0003, 1, 32'h0102_0304, 1'b1, 1'b0};

    // Reset values, checked while reset is held low.
    #1 reset = 1'b0;
    #1;
    chk("rst byte_ready", 64'(byte_ready), 64'd0);
    chk("rst mem_we", 64'(mem_we), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'(BASE));
    chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // Table-driven sessions.
    for (int r = 0; r < NV; r++) begin
      words.delete();
      words.push_back(tbl[r].w0);
      for (int i = 1; i < int'(tbl[r].n) && i < DEPTH; i++) words.push_back($urandom);
      run_session($sformatf("vec%0d", r), tbl[r].n, words, tbl[r].gap, xor_of(words, tbl[r].n), st);
      chk($sformatf("vec%0d done", r), 64'(st[1]), 64'(tbl[r].exp_done));
      chk($sformatf("vec%0d error", r), 64'(st[0]), 64'(tbl[r].exp_err));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Trailer byte decides the outcome.
    words.delete();
    words.push_back(32'h1122_3344);
    run_session("cks_ok", 16'd1, words, 0, 8'h44, st);
    chk("cks_ok done", 64'(st), 64'b10);
    run_session("cks_bad", 16'd1, words, 0, 8'h45, st);
    chk("cks_bad error", 64'(st), 64'b01);
`endif

    // Reset after the 2nd payload byte.
    got_wr.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hCA);
    send_byte(8'hFE);
    #2 reset = 1'b0;
    #1;
    chk("midrst byte_ready", 64'(byte_ready), 64'd0);
    chk("midrst mem_we", 64'(mem_we), 64'd0);
    chk("midrst mem_addr", 64'(mem_addr), 64'(BASE));
    chk("midrst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("midrst cpu_hold", 64'(cpu_hold), 64'd1);
    chk("midrst done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(3);
    chk("midrst no_write", 64'(got_wr.size()), 64'd0);
    words.delete();
    words.push_back(32'h1234_5678);
    run_session("after_rst", 16'd1, words, 0, xor_of(words, 16'd1), st);

    // A start pulse in the middle of LOAD must not restart the session.
    words.delete();
    words.push_back(32'hA5A5_0001);
    words.push_back(32'h5A5A_0002);
    exp_wr.delete();
    exp_wr.push_back({BASE, words[0]});
    exp_wr.push_back({BASE + 32'd4, words[1]});
    got_wr.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hA5);
    send_byte(8'hA5);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'h5A);
    send_byte(8'h00);
    send_byte(8'h02);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xor_of(words, 16'd2));
`endif
    finish_check("start_in_load", exp_wr, 2'b10, st);

    // Random sessions against the model.
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 3) == 0) n = 16'($urandom_range(DEPTH - 1, DEPTH + 1));
      else n = 16'($urandom_range(0, 5));
      gap = $urandom_range(0, 2);
      words.delete();
      for (int i = 0; i < int'(n) && i < DEPTH; i++) words.push_back($urandom);
      tr = xor_of(words, n);
      if ($urandom_range(0, 2) == 0) tr = tr ^ 8'($urandom_range(1, 255));
      run_session($sformatf("rnd%0d", r), n, words, gap, tr, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1);
  end

endmodule
